dbg_reg_access: RTL and testbench

//   Debug responder behind the processor's register-display port (dis/add -> A).

---
 rtl/dbg_reg_access.sv | 164 ++++++++++++++++
 tb/tb_dbg_reg_access.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_reg_access.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_reg_access
//  Description : Debug responder for general-purpose register reads/writes.
//                Halts the core at an instruction boundary, performs one
//                access on the register-file debug port, then acknowledges
//                over a four-phase dis/dbg_ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbg_reg_access #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dis,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] A,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic              cpu_halt_req,
    input  logic              cpu_halted,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HALT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
    logic              we_lat_q,   we_lat_d;
    logic [DATA_W-1:0] wdata_lat_q, wdata_lat_d;
    logic [DATA_W-1:0] a_q,        a_d;
    logic              ack_q,      ack_d;
    logic              err_q,      err_d;
    logic              halt_req_q, halt_req_d;
    logic [ADDR_W-1:0] rf_addr_q,  rf_addr_d;
    logic              rf_we_q,    rf_we_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    // Next-state and next-output logic; every output is registered, so the
    // register-file controls are computed on the HALT->ACCESS transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_lat_d  = addr_lat_q;
        we_lat_d    = we_lat_q;
        wdata_lat_d = wdata_lat_q;
        a_d         = a_q;
        ack_d       = ack_q;
        err_d       = err_q;
        halt_req_d  = halt_req_q;
        rf_addr_d   = rf_addr_q;
        rf_we_d     = 1'b0;
        rf_wdata_d  = rf_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (dis) begin
                    addr_lat_d  = add;
                    we_lat_d    = dbg_we;
                    wdata_lat_d = dbg_wdata;
                    cnt_d       = '0;
                    halt_req_d  = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!dis) begin
                    // Requester gave up before the core stalled: no access.
                    halt_req_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else if (cpu_halted) begin
                    rf_addr_d = addr_lat_q;
                    // r0 is hard-wired to zero, so its write strobe is masked.
                    rf_we_d   = we_lat_q && (addr_lat_q != '0);
                    if (we_lat_q) begin
                        rf_wdata_d = wdata_lat_q;
                    end
                    state_d = ST_ACCESS;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ACCESS: begin
                // Halt is not re-checked here: the access always completes.
                if (!we_lat_q) begin
                    a_d = rf_rdata;
                end
                ack_d   = 1'b1;
                err_d   = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!dis) begin
                    ack_d      = 1'b0;
                    err_d      = 1'b0;
                    halt_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_lat_q  <= '0;
            we_lat_q    <= 1'b0;
            wdata_lat_q <= '0;
            a_q         <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            halt_req_q  <= 1'b0;
            rf_addr_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_lat_q  <= addr_lat_d;
            we_lat_q    <= we_lat_d;
            wdata_lat_q <= wdata_lat_d;
            a_q         <= a_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            halt_req_q  <= halt_req_d;
            rf_addr_q   <= rf_addr_d;
            rf_we_q     <= rf_we_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    assign A            = a_q;
    assign dbg_ack      = ack_q;
    assign dbg_err      = err_q;
    assign cpu_halt_req = halt_req_q;
    assign rf_addr      = rf_addr_q;
    assign rf_we        = rf_we_q;
    assign rf_wdata     = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dbg_reg_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbg_reg_access
//  Description : Directed self-checking bench for dbg_reg_access with a
//                behavioural register file on the debug port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_reg_access;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              dis = 1'b0;
    logic              dbg_we = 1'b0;
    logic [ADDR_W-1:0] add = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] A;
    logic              dbg_ack;
    logic              dbg_err;
    logic              cpu_halt_req;
    logic              cpu_halted = 1'b0;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    int we_pulses = 0;

    logic [DATA_W-1:0] regs [32];

    dbg_reg_access #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dis          (dis),
        .dbg_we       (dbg_we),
        .add          (add),
        .dbg_wdata    (dbg_wdata),
        .A            (A),
        .dbg_ack      (dbg_ack),
        .dbg_err      (dbg_err),
        .cpu_halt_req (cpu_halt_req),
        .cpu_halted   (cpu_halted),
        .rf_addr      (rf_addr),
        .rf_rdata     (rf_rdata),
        .rf_we        (rf_we),
        .rf_wdata     (rf_wdata)
    );

    always #5 clock = ~clock;

    // Behavioural register file: r0 always reads zero.
    assign rf_rdata = (rf_addr == '0) ? '0 : regs[rf_addr];

    always @(posedge clock) begin
        if (rf_we) begin
            we_pulses <= we_pulses + 1;
            if (rf_addr != '0) regs[rf_addr] <= rf_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [4:0] a, input logic [31:0] d);
        dis = 1'b1; dbg_we = we; add = a; dbg_wdata = d;
    endtask

    int p0;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[5] = 32'h0000_00AB;

        // Reset state
        #12;
        chk("rst_A", A, 0);
        chk("rst_ack", {31'd0, dbg_ack}, 0);
        chk("rst_err", {31'd0, dbg_err}, 0);
        chk("rst_halt_req", {31'd0, cpu_halt_req}, 0);
        chk("rst_rf_we", {31'd0, rf_we}, 0);
        chk("rst_rf_addr", {27'd0, rf_addr}, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // 1. Read r5 with core already halted
        cpu_halted = 1'b1;
        start_req(1'b0, 5'd5, 32'h0);
        tick();                                   // edge N
        chk("rd_halt_req_n1", {31'd0, cpu_halt_req}, 1);
        chk("rd_ack_n1", {31'd0, dbg_ack}, 0);
        add = 5'd7;                               // ignored after sampling
        tick();                                   // edge N+1
        chk("rd_rf_we_n2", {31'd0, rf_we}, 0);
        chk("rd_rf_addr_n2", {27'd0, rf_addr}, 5);
        chk("rd_ack_n2", {31'd0, dbg_ack}, 0);
        tick();                                   // edge N+2
        chk("rd_ack_n3", {31'd0, dbg_ack}, 1);
        chk("rd_err_n3", {31'd0, dbg_err}, 0);
        chk("rd_A_n3", A, 32'h0000_00AB);
        dis = 1'b0;
        tick();
        chk("rd_ack_drop", {31'd0, dbg_ack}, 0);
        chk("rd_halt_req_drop", {31'd0, cpu_halt_req}, 0);

        // 2. Write 0xDEADBEEF to r9, then read it back
        p0 = we_pulses;
        start_req(1'b1, 5'd9, 32'hDEAD_BEEF);
        tick();
        dbg_wdata = 32'h1111_1111;                // ignored after sampling
        tick();
        chk("wr_rf_we", {31'd0, rf_we}, 1);
        chk("wr_rf_addr", {27'd0, rf_addr}, 9);
        chk("wr_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        tick();
        chk("wr_rf_we_single", {31'd0, rf_we}, 0);
        chk("wr_ack", {31'd0, dbg_ack}, 1);
        chk("wr_A_intact", A, 32'h0000_00AB);
        tick(); tick(); tick();                   // dis held: stay in DONE
        chk("wr_hold_ack", {31'd0, dbg_ack}, 1);
        chk("wr_hold_pulses", we_pulses - p0, 1);
        dis = 1'b0;
        tick();
        chk("wr_ack_drop", {31'd0, dbg_ack}, 0);
        chk("wr_model_r9", regs[9], 32'hDEAD_BEEF);
        start_req(1'b0, 5'd9, 32'h0);
        tick(); tick(); tick();
        chk("rd9_ack", {31'd0, dbg_ack}, 1);
        chk("rd9_A", A, 32'hDEAD_BEEF);
        dis = 1'b0;
        tick();

        // 3. Write to r0 is suppressed; read r0 gives 0
        p0 = we_pulses;
        start_req(1'b1, 5'd0, 32'h0000_1234);
        tick(); tick(); tick();
        chk("wr0_ack", {31'd0, dbg_ack}, 1);
        chk("wr0_err", {31'd0, dbg_err}, 0);
        chk("wr0_no_we", we_pulses - p0, 0);
        dis = 1'b0;
        tick();
        start_req(1'b0, 5'd0, 32'h0);
        tick(); tick(); tick();
        chk("rd0_A", A, 0);
        dis = 1'b0;
        tick();

        // 4. Delayed halt: cpu_halted rises 10 cycles after cpu_halt_req
        cpu_halted = 1'b0;
        start_req(1'b0, 5'd9, 32'h0);
        tick();
        chk("dly_halt_req", {31'd0, cpu_halt_req}, 1);
        for (int i = 0; i < 9; i++) tick();
        chk("dly_no_ack_yet", {31'd0, dbg_ack}, 0);
        cpu_halted = 1'b1;
        tick();
        cpu_halted = 1'b0;                        // falling during ACCESS is ignored
        chk("dly_ack_early", {31'd0, dbg_ack}, 0);
        tick();
        chk("dly_ack", {31'd0, dbg_ack}, 1);
        chk("dly_err", {31'd0, dbg_err}, 0);
        chk("dly_A", A, 32'hDEAD_BEEF);
        dis = 1'b0;
        tick();

        // 5. Timeout: core never halts
        p0 = we_pulses;
        cpu_halted = 1'b0;
        start_req(1'b1, 5'd12, 32'hCAFE_0000);
        tick();                                   // edge N, enter HALT
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("to_ack_before", {31'd0, dbg_ack}, 0);
        tick();                                   // TIMEOUT-th HALT cycle
        chk("to_ack", {31'd0, dbg_ack}, 1);
        chk("to_err", {31'd0, dbg_err}, 1);
        chk("to_A_intact", A, 32'hDEAD_BEEF);
        chk("to_no_we", we_pulses - p0, 0);
        dis = 1'b0;
        tick();
        chk("to_err_clear", {31'd0, dbg_err}, 0);
        chk("to_halt_req_clear", {31'd0, cpu_halt_req}, 0);

        // 6a. Abort in HALT
        start_req(1'b0, 5'd5, 32'h0);
        tick(); tick();
        chk("ab_halt_req", {31'd0, cpu_halt_req}, 1);
        dis = 1'b0;
        tick();
        chk("ab_halt_req_drop", {31'd0, cpu_halt_req}, 0);
        tick();
        chk("ab_no_ack", {31'd0, dbg_ack}, 0);
        chk("ab_A_intact", A, 32'hDEAD_BEEF);

        // 6b. Reset asserted while the write strobe is high
        cpu_halted = 1'b1;
        start_req(1'b1, 5'd3, 32'h5555_AAAA);
        tick(); tick();
        chk("rs_rf_we_pre", {31'd0, rf_we}, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_rf_we", {31'd0, rf_we}, 0);
        chk("rs_A", A, 0);
        chk("rs_halt_req", {31'd0, cpu_halt_req}, 0);
        chk("rs_rf_addr", {27'd0, rf_addr}, 0);
        chk("rs_ack", {31'd0, dbg_ack}, 0);
        dis = 1'b0;
        tick();
        chk("rs_r3_untouched", regs[3], 0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("rs_idle_no_ack", {31'd0, dbg_ack}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
